target_bank_fsm: RTL and testbench

// - Multi-target successor of the single-target sequencer: NUM_TARGETS independent target lifecycles.
// - Each target runs WAIT -> CLEAR -> FADE -> TAR -> HIT/ESCAPE -> CLEAR.
// - Sits between the spawn/collision logic and the sprite renderer/score keeper.
// - Adds per-target escape timeout, one-cycle hit/escape event pulses and a live-target count.

---
 rtl/target_pkg.sv | 17 +
 rtl/target_bank_fsm_if.sv | 42 ++++
 rtl/target_channel_fsm.sv | 84 ++++++++
 rtl/target_bank_fsm.sv | 61 ++++++
 tb/tb_target_bank_fsm.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/target_pkg.sv
// Shared definitions for the target bank.
//   STATE_W          width of one channel's state encoding
//   target_state_e   per-channel lifecycle states
package target_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    T_WAIT   = 3'd0,
    T_CLEAR  = 3'd1,
    T_FADE   = 3'd2,
    T_TAR    = 3'd3,
    T_HIT    = 3'd4,
    T_ESCAPE = 3'd5
  } target_state_e;

endpackage

// File: rtl/target_bank_fsm_if.sv
// Signal bundle between the spawn/collision logic (master) and the target
// bank (slave). The renderer and score keeper observe the slave outputs.
//   titleoff, over      game-level controls
//   spawn, kill         per-target requests
//   clear/fade/tar/hit  one-hot Moore state per target
//   hit_pulse/esc_pulse one-cycle event pulses
//   live_count          number of targets in TAR
//   state_dbg           raw per-channel state, channel i at [i*STATE_W +: STATE_W]
//
// Signalling: there is no valid/ready pairing here. spawn and kill are levels
// sampled on every rising clk edge; the bank never back-pressures. A request
// that arrives while its channel cannot act on it is dropped, not queued.
interface target_bank_fsm_if
  import target_pkg::*;
#(
  parameter int NUM_TARGETS = 4
);
  localparam int LC_W = $clog2(NUM_TARGETS + 1);

  logic                           titleoff;
  logic                           over;
  logic [NUM_TARGETS-1:0]         spawn;
  logic [NUM_TARGETS-1:0]         kill;
  logic [NUM_TARGETS-1:0]         clear;
  logic [NUM_TARGETS-1:0]         fade;
  logic [NUM_TARGETS-1:0]         tar;
  logic [NUM_TARGETS-1:0]         hit;
  logic [NUM_TARGETS-1:0]         hit_pulse;
  logic [NUM_TARGETS-1:0]         esc_pulse;
  logic [LC_W-1:0]                live_count;
  logic [NUM_TARGETS*STATE_W-1:0] state_dbg;

  modport master (
    output titleoff, over, spawn, kill,
    input  clear, fade, tar, hit, hit_pulse, esc_pulse, live_count, state_dbg
  );

  modport slave (
    input  titleoff, over, spawn, kill,
    output clear, fade, tar, hit, hit_pulse, esc_pulse, live_count, state_dbg
  );
endinterface

// File: rtl/target_channel_fsm.sv
// One target lifecycle: WAIT -> CLEAR -> FADE -> TAR -> HIT/ESCAPE -> CLEAR.
//   clk, resetn       clock, async active-low reset
//   abort             forces WAIT from any state, highest priority
//   spawn, kill       level requests for this channel
//   clear/fade/tar/hit  Moore state decode
//   hit_pulse/esc_pulse registered, high in the first HIT / ESCAPE cycle
//   state_dbg         current state register
module target_channel_fsm
  import target_pkg::*;
#(
  parameter int TIMER_W       = 26,
  parameter int FADE_CYCLES   = 15000000,
  parameter int HIT_CYCLES    = 15000000,
  parameter int ESCAPE_CYCLES = 50000000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               abort,
  input  logic               spawn,
  input  logic               kill,
  output logic               clear,
  output logic               fade,
  output logic               tar,
  output logic               hit,
  output logic               hit_pulse,
  output logic               esc_pulse,
  output logic [STATE_W-1:0] state_dbg
);
  // Exit compares against N-1 so a state is occupied for exactly N cycles.
  localparam logic [TIMER_W-1:0] FADE_LAST = TIMER_W'(FADE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HIT_LAST  = TIMER_W'(HIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] ESC_LAST  =
    TIMER_W'((ESCAPE_CYCLES == 0) ? 0 : ESCAPE_CYCLES - 1);
  localparam logic               ESC_EN    = (ESCAPE_CYCLES != 0);

  target_state_e      state_q, state_d;
  logic [TIMER_W-1:0] timer_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= T_WAIT;
      timer_q   <= '0;
      hit_pulse <= 1'b0;
      esc_pulse <= 1'b0;
    end else begin
      state_q <= state_d;
      // Timer restarts on any state change and sticks at all-ones.
      if (state_d != state_q) timer_q <= '0;
      else if (timer_q != '1) timer_q <= timer_q + TIMER_W'(1);
      // An abort drives state_d to WAIT, which suppresses both pulses.
      hit_pulse <= (state_q == T_TAR) && (state_d == T_HIT);
      esc_pulse <= (state_q == T_TAR) && (state_d == T_ESCAPE);
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = T_WAIT;
    end else begin
      unique case (state_q)
        T_WAIT:   state_d = T_CLEAR;
        T_CLEAR:  if (spawn) state_d = T_FADE;
        T_FADE:   if (timer_q == FADE_LAST) state_d = T_TAR;
        T_TAR: begin
          // kill on the last TAR cycle beats the escape.
          if (kill) state_d = T_HIT;
          else if (ESC_EN && (timer_q == ESC_LAST)) state_d = T_ESCAPE;
        end
        T_HIT:    if (timer_q == HIT_LAST) state_d = T_CLEAR;
        T_ESCAPE: state_d = T_CLEAR;
        default:  state_d = T_WAIT;
      endcase
    end
  end

  always_comb begin
    clear     = (state_q == T_CLEAR);
    fade      = (state_q == T_FADE);
    tar       = (state_q == T_TAR);
    hit       = (state_q == T_HIT);
    state_dbg = state_q;
  end
endmodule

// File: rtl/target_bank_fsm.sv
// Bank of NUM_TARGETS independent target channels.
//   clk, resetn   clock, async active-low reset
//   bus           target_bank_fsm_if slave side (controls, requests, outputs)
module target_bank_fsm
  import target_pkg::*;
#(
  parameter int NUM_TARGETS   = 4,
  parameter int TIMER_W       = 26,
  parameter int FADE_CYCLES   = 15000000,
  parameter int HIT_CYCLES    = 15000000,
  parameter int ESCAPE_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              resetn,
  target_bank_fsm_if.slave  bus
);
  localparam int LC_W = $clog2(NUM_TARGETS + 1);

  logic                           abort;
  logic [NUM_TARGETS-1:0]         clear_v, fade_v, tar_v, hit_v, hp_v, ep_v;
  logic [NUM_TARGETS*STATE_W-1:0] state_v;
  logic [LC_W-1:0]                live_cnt;

  assign abort = !bus.titleoff || bus.over;

  for (genvar g = 0; g < NUM_TARGETS; g++) begin : g_ch
    target_channel_fsm #(
      .TIMER_W      (TIMER_W),
      .FADE_CYCLES  (FADE_CYCLES),
      .HIT_CYCLES   (HIT_CYCLES),
      .ESCAPE_CYCLES(ESCAPE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .abort     (abort),
      .spawn     (bus.spawn[g]),
      .kill      (bus.kill[g]),
      .clear     (clear_v[g]),
      .fade      (fade_v[g]),
      .tar       (tar_v[g]),
      .hit       (hit_v[g]),
      .hit_pulse (hp_v[g]),
      .esc_pulse (ep_v[g]),
      .state_dbg (state_v[g*STATE_W +: STATE_W])
    );
  end

  always_comb begin
    live_cnt = '0;
    for (int i = 0; i < NUM_TARGETS; i++) live_cnt = live_cnt + LC_W'(tar_v[i]);
  end

  assign bus.clear      = clear_v;
  assign bus.fade       = fade_v;
  assign bus.tar        = tar_v;
  assign bus.hit        = hit_v;
  assign bus.hit_pulse  = hp_v;
  assign bus.esc_pulse  = ep_v;
  assign bus.live_count = live_cnt;
  assign bus.state_dbg  = state_v;
endmodule

// File: tb/tb_target_bank_fsm.sv
// Bench for target_bank_fsm with NUM_TARGETS=4, FADE=4, HIT=3, ESCAPE=8, TIMER_W=8.
module tb_target_bank_fsm;
  localparam int N      = 4;
  localparam int FADE_N = 4;
  localparam int HIT_N  = 3;
  localparam int ESC_N  = 8;
  localparam int W      = 6 * N + 3;

  // Reference phases of a target slot.
  localparam int P_IDLE = 10, P_EMPTY = 11, P_FADING = 12;
  localparam int P_LIVE = 13, P_DYING = 14, P_GONE = 15;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  target_bank_fsm_if #(.NUM_TARGETS(N)) bus ();

  target_bank_fsm #(
    .NUM_TARGETS(N), .TIMER_W(8), .FADE_CYCLES(FADE_N),
    .HIT_CYCLES(HIT_N), .ESCAPE_CYCLES(ESC_N)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  // ---------------- clock / timeout ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  int ph[N];
  int age[N];  // cycles already completed in the current phase
  logic [N-1:0] m_clear, m_fade, m_tar, m_hit, m_hp, m_ep;
  logic [2:0]   m_live;
  logic [W-1:0] exp_q[$];

  task automatic model_outputs();
    m_live = 0;
    for (int i = 0; i < N; i++) begin
      m_clear[i] = (ph[i] == P_EMPTY);
      m_fade[i]  = (ph[i] == P_FADING);
      m_tar[i]   = (ph[i] == P_LIVE);
      m_hit[i]   = (ph[i] == P_DYING);
      if (ph[i] == P_LIVE) m_live = m_live + 3'd1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin ph[i] = P_IDLE; age[i] = 0; end
    m_hp = '0;
    m_ep = '0;
    model_outputs();
  endtask

  task automatic model_step();
    bit ab;
    int nx;
    if (!resetn) begin model_reset(); return; end
    ab = !bus.titleoff || bus.over;
    for (int i = 0; i < N; i++) begin
      nx = ph[i];
      if (ab) nx = P_IDLE;
      else if (ph[i] == P_IDLE) nx = P_EMPTY;
      else if (ph[i] == P_EMPTY && bus.spawn[i]) nx = P_FADING;
      else if (ph[i] == P_FADING && age[i] + 1 == FADE_N) nx = P_LIVE;
      else if (ph[i] == P_LIVE && bus.kill[i]) nx = P_DYING;
      else if (ph[i] == P_LIVE && age[i] + 1 == ESC_N) nx = P_GONE;
      else if (ph[i] == P_DYING && age[i] + 1 == HIT_N) nx = P_EMPTY;
      else if (ph[i] == P_GONE) nx = P_EMPTY;
      m_hp[i] = (ph[i] == P_LIVE) && (nx == P_DYING);
      m_ep[i] = (ph[i] == P_LIVE) && (nx == P_GONE);
      age[i]  = (nx == ph[i]) ? age[i] + 1 : 0;
      ph[i]   = nx;
    end
    model_outputs();
  endtask

  // Advance one clock: inputs already set, model follows the edge, return mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; bus.titleoff = 1'b1; bus.over = 1'b0;
    bus.spawn = '0; bus.kill = '0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({bus.clear, bus.fade, bus.tar, bus.hit, bus.hit_pulse, bus.esc_pulse, bus.live_count} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b want=0",
        {bus.clear, bus.fade, bus.tar, bus.hit, bus.hit_pulse, bus.esc_pulse, bus.live_count});
    end
    resetn = 1'b1;
    tick(); tick();
    total++;
    if (bus.clear !== m_clear || m_clear !== 4'b1111) begin
      bad++; $display("FAIL reset_entry_clear got=%b want=%b", bus.clear, 4'b1111);
    end
    // Run into TAR, then pull reset mid-run.
    bus.spawn = 4'b1111; tick(); bus.spawn = '0;
    repeat (5) tick();
    total++;
    if (bus.tar !== m_tar) begin
      bad++; $display("FAIL reset_prerun_tar got=%b want=%b", bus.tar, m_tar);
    end
    resetn = 1'b0;
    #1;
    model_reset();
    total++;
    if ({bus.clear, bus.fade, bus.tar, bus.hit, bus.live_count} !== '0) begin
      bad++; $display("FAIL reset_async got=%b want=0",
        {bus.clear, bus.fade, bus.tar, bus.hit, bus.live_count});
    end
    @(negedge clk);
    resetn = 1'b1;
    tick(); tick();
    total++;
    if (bus.clear !== 4'b1111 || bus.clear !== m_clear) begin
      bad++; $display("FAIL reset_reentry got=%b want=%b", bus.clear, m_clear);
    end
  endtask

  task automatic test_spawn_kill();
    int n, np;
    bus.spawn = 4'b0001; tick(); bus.spawn = '0;
    n = 0;
    while (bus.fade[0] === 1'b1 && n < 50) begin n++; tick(); end
    total++;
    if (n != FADE_N) begin bad++; $display("FAIL sk_fade_len got=%0d want=%0d", n, FADE_N); end
    total++;
    if (bus.tar !== m_tar || bus.tar[0] !== 1'b1) begin
      bad++; $display("FAIL sk_tar got=%b want=%b", bus.tar, m_tar);
    end
    tick();
    bus.kill = 4'b0001; tick(); bus.kill = '0;
    total++;
    if (bus.hit_pulse !== m_hp || bus.hit_pulse !== 4'b0001) begin
      bad++; $display("FAIL sk_hit_pulse got=%b want=%b", bus.hit_pulse, m_hp);
    end
    n = 0; np = 0;
    while (bus.hit[0] === 1'b1 && n < 50) begin
      n++; if (bus.hit_pulse[0] === 1'b1) np++; tick();
    end
    total++;
    if (n != HIT_N || np != 1) begin
      bad++; $display("FAIL sk_hit_len got=%0d/%0d want=%0d/1", n, np, HIT_N);
    end
    total++;
    if (bus.clear !== m_clear || bus.clear[0] !== 1'b1) begin
      bad++; $display("FAIL sk_back_clear got=%b want=%b", bus.clear, m_clear);
    end
  endtask

  task automatic test_escape();
    int n;
    bus.spawn = 4'b0010; tick(); bus.spawn = '0;
    n = 0;
    while (bus.fade[1] === 1'b1 && n < 50) begin n++; tick(); end
    n = 0;
    while (bus.tar[1] === 1'b1 && n < 50) begin n++; tick(); end
    total++;
    if (n != ESC_N) begin bad++; $display("FAIL esc_tar_len got=%0d want=%0d", n, ESC_N); end
    total++;
    if (bus.esc_pulse !== m_ep || bus.esc_pulse[1] !== 1'b1 ||
        {bus.clear[1], bus.fade[1], bus.tar[1], bus.hit[1]} !== 4'b0000) begin
      bad++; $display("FAIL esc_pulse got=%b want=%b", bus.esc_pulse, m_ep);
    end
    tick();
    total++;
    if (bus.clear[1] !== 1'b1 || bus.esc_pulse !== m_ep) begin
      bad++; $display("FAIL esc_back_clear got=%b want=1", bus.clear[1]);
    end
    // kill on the last TAR cycle wins over the escape
    bus.spawn = 4'b0010; tick(); bus.spawn = '0;
    n = 0;
    while (bus.fade[1] === 1'b1 && n < 50) begin n++; tick(); end
    repeat (ESC_N - 1) tick();
    total++;
    if (bus.tar[1] !== 1'b1 || bus.tar !== m_tar) begin
      bad++; $display("FAIL esc_last_tar got=%b want=%b", bus.tar, m_tar);
    end
    bus.kill = 4'b0010; tick(); bus.kill = '0;
    total++;
    if (bus.hit[1] !== 1'b1 || bus.esc_pulse !== 4'b0000 || bus.hit_pulse !== 4'b0010 ||
        bus.hit_pulse !== m_hp) begin
      bad++; $display("FAIL esc_kill_wins got=%b/%b want=0010/0000", bus.hit_pulse, bus.esc_pulse);
    end
    n = 0;
    while (bus.clear[1] !== 1'b1 && n < 50) begin n++; tick(); end
  endtask

  task automatic test_concurrency();
    bus.spawn = 4'b1111; tick(); bus.spawn = '0;
    repeat (FADE_N) tick();
    total++;
    if (bus.live_count !== m_live || bus.live_count !== 3'd4) begin
      bad++; $display("FAIL conc_live4 got=%0d want=4", bus.live_count);
    end
    bus.kill = 4'b0101; tick(); bus.kill = '0;
    total++;
    if (bus.live_count !== m_live || bus.live_count !== 3'd2) begin
      bad++; $display("FAIL conc_live2 got=%0d want=2", bus.live_count);
    end
    total++;
    if (bus.hit_pulse !== m_hp || bus.hit_pulse !== 4'b0101) begin
      bad++; $display("FAIL conc_hit_pulse got=%b want=0101", bus.hit_pulse);
    end
    repeat (12) tick();
    total++;
    if (bus.clear !== m_clear || bus.clear !== 4'b1111) begin
      bad++; $display("FAIL conc_settle got=%b want=1111", bus.clear);
    end
  endtask

  task automatic test_abort();
    bus.spawn = 4'b0001; tick();
    bus.spawn = 4'b0010; tick();
    bus.spawn = '0; repeat (3) tick();
    bus.kill = 4'b0001; bus.spawn = 4'b0100; tick();
    bus.kill = '0; bus.spawn = '0;
    total++;
    if ({bus.hit[0], bus.tar[1], bus.fade[2]} !== 3'b111 || bus.hit !== m_hit) begin
      bad++; $display("FAIL abort_setup got=%b want=111", {bus.hit[0], bus.tar[1], bus.fade[2]});
    end
    bus.over = 1'b1; tick();
    total++;
    if ({bus.clear, bus.fade, bus.tar, bus.hit, bus.hit_pulse, bus.esc_pulse} !== '0 ||
        {m_clear, m_fade, m_tar, m_hit} !== '0) begin
      bad++; $display("FAIL abort_wait got=%b want=0",
        {bus.clear, bus.fade, bus.tar, bus.hit, bus.hit_pulse, bus.esc_pulse});
    end
    bus.over = 1'b0; tick();
    total++;
    if (bus.clear !== 4'b1111 || bus.clear !== m_clear) begin
      bad++; $display("FAIL abort_resume got=%b want=1111", bus.clear);
    end
  endtask

  task automatic test_ignored();
    int n;
    bus.spawn = 4'b1000; tick(); bus.spawn = '0;
    bus.kill = 4'b1000;
    n = 0;
    while (bus.fade[3] === 1'b1 && n < 50) begin n++; tick(); end
    bus.kill = '0;
    total++;
    if (n != FADE_N || bus.tar !== m_tar) begin
      bad++; $display("FAIL ign_kill_in_fade got=%0d want=%0d", n, FADE_N);
    end
    bus.spawn = 4'b1000; repeat (3) tick(); bus.spawn = '0;
    n = 3;
    while (bus.tar[3] === 1'b1 && n < 50) begin n++; tick(); end
    total++;
    if (n != ESC_N || bus.esc_pulse !== m_ep || bus.esc_pulse[3] !== 1'b1) begin
      bad++; $display("FAIL ign_spawn_in_tar got=%0d want=%0d", n, ESC_N);
    end
    tick();
  endtask

  task automatic test_saturation();
    int n;
    bus.titleoff = 1'b0; repeat (300) tick();
    total++;
    if ({bus.clear, bus.fade, bus.tar, bus.hit} !== {m_clear, m_fade, m_tar, m_hit} ||
        bus.clear !== 4'b0000) begin
      bad++; $display("FAIL sat_wait got=%b want=0", {bus.clear, bus.fade, bus.tar, bus.hit});
    end
    bus.titleoff = 1'b1; repeat (301) tick();
    total++;
    if (bus.clear !== 4'b1111 || bus.clear !== m_clear) begin
      bad++; $display("FAIL sat_clear got=%b want=1111", bus.clear);
    end
    bus.spawn = 4'b0100; tick(); bus.spawn = '0;
    n = 0;
    while (bus.fade[2] === 1'b1 && n < 50) begin n++; tick(); end
    total++;
    if (n != FADE_N) begin bad++; $display("FAIL sat_fade_len got=%0d want=%0d", n, FADE_N); end
    n = 0;
    while (bus.tar[2] === 1'b1 && n < 50) begin n++; tick(); end
    total++;
    if (n != ESC_N) begin bad++; $display("FAIL sat_tar_len got=%0d want=%0d", n, ESC_N); end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] exp_v, got_v;
    int errs = 0;
    for (int c = 0; c < 600; c++) begin
      bus.titleoff = ($urandom_range(0, 80) != 0);
      bus.over     = ($urandom_range(0, 80) == 0);
      bus.spawn    = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) bus.kill[i] = ($urandom_range(0, 5) == 0);
      tick();
      exp_q.push_back({m_clear, m_fade, m_tar, m_hit, m_hp, m_ep, m_live});
      got_v = {bus.clear, bus.fade, bus.tar, bus.hit, bus.hit_pulse, bus.esc_pulse, bus.live_count};
      exp_v = exp_q.pop_front();
      total++;
      if (got_v !== exp_v) begin
        bad++;
        if (errs < 10) $display("FAIL random_cycle%0d got=%h want=%h", c, got_v, exp_v);
        errs++;
      end
    end
    bus.spawn = '0; bus.kill = '0; bus.over = 1'b0; bus.titleoff = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_spawn_kill();
    test_escape();
    test_concurrency();
    test_abort();
    test_ignored();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
